gate_reduce_pipe: RTL
=====================

# gate_reduce_pipe

Parametrised, pipelined N-input logic reduction gate with a runtime-selectable function (NOR, OR, AND, NAND, XOR, XNOR). It generalises the fixed-width combinational gate macros of the schematic library: it accepts any input width, reduces it through a registered tree of bounded fan-in for timing closure, and carries a valid flag and clock enable alongside the data. It sits between wide status/flag buses and control logic that needs a registered combined indication.

## Interface
- WIDTH, 7: number of input bits, at least 2.
- FANIN, 4: maximum inputs per tree node per level, at least 2.
- LEVELS, derived (not overridable): smallest L with FANIN^L >= WIDTH.

- CK  in  1  clock; all state updates on the rising edge.
- RN  in  1  reset, asynchronous and active-low.
- CE  in  1  clock enable; when low, the whole pipeline holds.
- VI  in  1  input sample valid.
- FN  in  3  function select: 0 NOR, 1 OR, 2 AND, 3 NAND, 4 XOR, 5 XNOR, 6/7 NOR.
- A   in  WIDTH  operand bits, A[0] to A[WIDTH-1].
- VO  out 1  output valid.
- ZN0 out 1  reduction result.

## Operation
- Stage 0 (input register): on CK with CE=1, capture A, FN and VI.
- Tree levels 1..LEVELS, each registered:
  - Level k groups the previous level's bits in index order, FANIN per node; the last node may be partial.
  - Missing node inputs are padded with the identity element: 0 for OR-class and XOR-class, 1 for AND-class.
- FN travels with its sample through every stage, so a function change mid-stream affects only samples captured after the change.
- Base operation per class:
  - OR-class (0, 1, 6, 7): OR.
  - AND-class (2, 3): AND.
  - XOR-class (4, 5): XOR.
- Final inversion for FN 0, 3, 5, 6, 7 is applied combinationally before the last level register. ZN0 is a direct flop output.
- The result is computed for every captured sample regardless of VI. VI only qualifies the result through VO.
- VO is VI delayed through the same 1+LEVELS stages.
- Reset (RN low, asynchronous): all data, FN and valid registers clear to 0 immediately. ZN0=0 and VO=0 while RN is low and until the first valid sample emerges.
- Release of RN is synchronised by the integrator upstream. The block needs no internal reset synchroniser.
- Reset mid-operation discards all in-flight samples. No partial results appear after release.

## Timing
- Latency: a sample captured at edge n appears on ZN0/VO after edge n+LEVELS. That is 1+LEVELS register stages in total.
- Default parameters: LEVELS=2, latency 3 edges.
  - Level 1: nodes {A0..A3} and {A4..A6, pad}.
  - Level 2: one node of two inputs.
- Throughput: one sample per CK while CE=1. There is no back-pressure; the consumer must accept VO pulses.
- CE=0 freezes every stage, including VO and ZN0. Deasserting and reasserting CE produces no duplication or loss; the output sequence equals the CE=1 sequence with stall gaps inserted.
- CE is ignored during reset. Reset dominates.
- WIDTH <= FANIN gives LEVELS=1 and latency 2.

## Test plan
- Reset then NOR, default params: hold RN=0 with A=7'h00 and VI=1, then release and apply A=7'h00, FN=0, VI=1 for one cycle -> ZN0=0 and VO=0 during reset; ZN0=1 and VO=1 for exactly one cycle, 3 edges after capture.
- Function sweep on back-to-back samples with FN=0..5 and A=7'h01:
  - Outputs on consecutive cycles: 0, 1, 0, 1, 1, 0.
  - Repeat with A=7'h7F: 0, 1, 1, 0, 1, 0.
- Padding check, WIDTH=7, FANIN=4: FN=2 (AND) with A=7'h7F -> ZN0=1, which confirms pad=1. FN=4 (XOR) with A=7'h40 -> ZN0=1, which confirms pad=0.
- Stall: stream A=7'h00, 7'h01, 7'h00 with FN=0 and VI=1, and drop CE for 2 cycles after the second capture -> VO/ZN0 show 1, 0, 1 in order. During the stall VO and ZN0 hold, and no extra VO pulses appear.
- Mid-stream reset: with 3 samples in flight, pulse RN low asynchronously between edges -> VO and ZN0 drop to 0 immediately, and no VO appears after release until a new VI=1 is captured.
- Parameter sweep: WIDTH in {2, 4, 5, 16, 17} with FANIN in {2, 4}, and FN=6/7 -> latency equals 1+ceil(log_FANIN WIDTH), and results match a reference NOR model over 1000 random samples.

Source files
------------

// File: rtl/gate_reduce_pipe.sv
// Pipelined N-input reduction gate (NOR/OR/AND/NAND/XOR/XNOR) built as a
// registered tree of bounded fan-in; function and valid travel with each sample.
module gate_reduce_pipe #(
  parameter int WIDTH = 7,
  parameter int FANIN = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             CE,
  input  logic             VI,
  input  logic [2:0]       FN,
  input  logic [WIDTH-1:0] A,
  output logic             VO,
  output logic             ZN0
);

  function automatic int calc_levels();
    int l;
    int p;
    l = 0;
    p = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (p < WIDTH) begin
        p = p * FANIN;
        l = l + 1;
      end
    end
    return l;
  endfunction

  function automatic int lvl_width(int unsigned k);
    int w;
    w = WIDTH;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < k) w = (w + FANIN - 1) / FANIN;
    end
    return w;
  endfunction

  function automatic int lvl_off(int unsigned k);
    int o;
    o = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < k) o = o + lvl_width(i);
    end
    return o;
  endfunction

  localparam int LEVELS = calc_levels();
  // All stages packed into one vector: stage k occupies lvl_width(k) bits at lvl_off(k).
  localparam int TOTAL  = lvl_off(LEVELS + 1);

  logic [TOTAL-1:0]    data_q;
  logic [TOTAL-1:0]    data_d;
  logic [3*LEVELS-1:0] fn_q;
  logic [3*LEVELS-1:0] fn_d;
  logic [LEVELS:0]     vld_q;

  assign data_d[WIDTH-1:0] = A;

  if (LEVELS == 1) begin : g_fn_one
    assign fn_d = FN;
  end else begin : g_fn_many
    assign fn_d = {fn_q[3*LEVELS-4:0], FN};
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int IW = lvl_width(k - 1);
    localparam int OW = lvl_width(k);
    localparam int IO = lvl_off(k - 1);
    localparam int OO = lvl_off(k);
    localparam bit LAST = (k == LEVELS);

    logic [2:0] fn;
    logic       and_cls;
    logic       xor_cls;
    logic       inv;

    assign fn      = fn_q[3*(k-1) +: 3];
    assign and_cls = (fn == 3'd2) || (fn == 3'd3);
    assign xor_cls = (fn == 3'd4) || (fn == 3'd5);
    assign inv     = LAST && !((fn == 3'd1) || (fn == 3'd2) || (fn == 3'd4));

    for (genvar n = 0; n < OW; n++) begin : g_node
      logic [FANIN-1:0] bits;
      logic             r;
      // Missing inputs of a partial node take the identity of the base operation.
      for (genvar i = 0; i < FANIN; i++) begin : g_in
        if (n * FANIN + i < IW) begin : g_real
          assign bits[i] = data_q[IO + n*FANIN + i];
        end else begin : g_pad
          assign bits[i] = and_cls;
        end
      end
      assign r = and_cls ? (&bits) : (xor_cls ? (^bits) : (|bits));
      assign data_d[OO + n] = r ^ inv;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      data_q <= '0;
      fn_q   <= '0;
      vld_q  <= '0;
    end else if (CE) begin
      data_q <= data_d;
      fn_q   <= fn_d;
      vld_q  <= {vld_q[LEVELS-1:0], VI};
    end
  end

  assign VO  = vld_q[LEVELS];
  assign ZN0 = data_q[TOTAL-1];

endmodule
